// File: rtl/readout_deserializer.sv
// Multi-lane serial frame receiver: one FSM per lane, per-lane holding registers, round-robin output stage.
// Define READOUT_RX_PARITY_EN to expect an even-parity bit between the last data bit and the stop bit.
module readout_deserializer #(
  parameter int LANES = 8,
  parameter int WIDTH = 15
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [LANES-1:0]         ser_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(LANES)-1:0] out_lane,
  output logic                     out_err,
  output logic [LANES-1:0]         overrun,
  input  logic                     clear_overrun,
  output logic [2*LANES-1:0]       lane_state
);
  localparam int LW = $clog2(LANES);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } lane_state_e;

  logic [LANES-1:0] done;
  logic [LANES-1:0] done_err;
  logic [WIDTH-1:0] done_data [LANES];
  logic [WIDTH-1:0] hold_data [LANES];
  logic [LANES-1:0] hold_err;
  logic [LANES-1:0] pending;
  logic [LANES-1:0] drain;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_state_e      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_err_q, par_err_d;
    logic             lane_done, lane_err;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        shift_q   <= '0;
        par_err_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        shift_q   <= shift_d;
        par_err_q <= par_err_d;
      end
    end

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      par_err_d = par_err_q;
      lane_done = 1'b0;
      lane_err  = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ser_in[g]) begin
            state_d   = ST_DATA;
            cnt_d     = '0;
            par_err_d = 1'b0;
          end
        end
        ST_DATA: begin
          shift_d = (shift_q << 1) | WIDTH'(ser_in[g]);
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d = '0;
`ifdef READOUT_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
        ST_PARITY: begin
          // Even parity: data bits plus parity bit must hold an even number of ones.
          par_err_d = ^{shift_q, ser_in[g]};
          state_d   = ST_STOP;
        end
        ST_STOP: begin
          // A stop bit of 1 flags the word but it is still delivered.
          lane_done = 1'b1;
          lane_err  = ser_in[g] | par_err_q;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    assign done[g]               = lane_done;
    assign done_err[g]           = lane_err;
    assign done_data[g]          = shift_q;
    assign lane_state[2*g +: 2]  = state_q;
  end

  // Output handshake: a word transfers on any edge where out_valid && out_ready;
  // out_data/out_lane/out_err are held while out_valid && !out_ready.
  logic          load;
  logic          grant_found;
  logic [LW-1:0] grant_idx, cand, rr_ptr, rr_next;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < LANES; k++) begin
      cand = LW'((int'(rr_ptr) + k) % LANES);
      if (!grant_found && pending[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign load    = !out_valid || out_ready;
  assign drain   = (load && grant_found) ? (LANES'(1) << grant_idx) : '0;
  assign rr_next = (grant_idx == LW'(LANES - 1)) ? '0 : grant_idx + 1'b1;

  // Completion and drain in the same cycle keeps pending set without an overrun.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < LANES; i++) hold_data[i] <= '0;
      hold_err <= '0;
      pending  <= '0;
      overrun  <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (done[i]) begin
          hold_data[i] <= done_data[i];
          hold_err[i]  <= done_err[i];
        end
      end
      pending <= (pending & ~drain) | done;
      overrun <= (clear_overrun ? '0 : overrun) | (done & pending & ~drain);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lane  <= '0;
      out_err   <= 1'b0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (grant_found) begin
        out_valid <= 1'b1;
        out_data  <= hold_data[grant_idx];
        out_lane  <= grant_idx;
        out_err   <= hold_err[grant_idx];
        rr_ptr    <= rr_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_readout_deserializer.sv
// Directed bench for readout_deserializer: latency, ordering, errors, overrun, reset and optional parity.
module tb_readout_deserializer;
  localparam int LANES = 8;
  localparam int WIDTH = 15;
`ifdef READOUT_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = WIDTH + 2 + PAR;

  logic               CLK;
  logic               RST_N;
  logic [LANES-1:0]   ser_in;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_lane;
  logic               out_err;
  logic [LANES-1:0]   overrun;
  logic               clear_overrun;
  logic [2*LANES-1:0] lane_state;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] tx_word [LANES];
  logic             tx_stop [LANES];
  logic             tx_flip [LANES];

  readout_deserializer #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .ser_in(ser_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane),
    .out_err(out_err), .overrun(overrun), .clear_overrun(clear_overrun),
    .lane_state(lane_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic apply_reset();
    RST_N = 1'b0;
    ser_in = '0;
    out_ready = 1'b0;
    clear_overrun = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      tx_word[l] = '0;
      tx_stop[l] = 1'b0;
      tx_flip[l] = 1'b0;
    end
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
  endtask

  // driver
  function automatic logic frame_bit(input int l, input int t);
    logic [WIDTH-1:0] w;
    w = tx_word[l];
    if (t == 0) return 1'b1;
    if (t <= WIDTH) return w[WIDTH - t];
    if (PAR == 1 && t == WIDTH + 1) return (^w) ^ tx_flip[l];
    return tx_stop[l];
  endfunction

  // Drives one frame on every lane in mask; returns with the stop bit on the line.
  task automatic send_frames(input logic [LANES-1:0] mask);
    for (int t = 0; t < FL; t++) begin
      @(posedge CLK);
      #1;
      for (int l = 0; l < LANES; l++)
        if (mask[l]) ser_in[l] = frame_bit(l, t);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    ser_in = '0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    ser_in = '0;
    out_ready = 1'b0;
    clear_overrun = 1'b0;
    @(posedge CLK);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 15'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
    total++; if (out_lane !== 3'd0) begin bad++; $display("FAIL reset_lane got=%0d exp=0", out_lane); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", out_err); end
    total++; if (overrun !== 8'h00) begin bad++; $display("FAIL reset_overrun got=%h exp=00", overrun); end
    total++; if (lane_state !== 16'h0) begin bad++; $display("FAIL reset_state got=%h exp=0000", lane_state); end
  endtask

  task automatic test_single_frame();
    apply_reset();
    out_ready = 1'b1;
    tx_word[0] = 15'h1234;
    send_frames(8'h01);
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 15'h1234) begin bad++; $display("FAIL single_data got=%h exp=1234", out_data); end
    total++; if (out_lane !== 3'd0) begin bad++; $display("FAIL single_lane got=%0d exp=0", out_lane); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", out_err); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drop got=%b exp=0", out_valid); end
    total++; if (lane_state !== 16'h0) begin bad++; $display("FAIL single_idle got=%h exp=0000", lane_state); end
  endtask

  task automatic test_all_lanes();
    logic [WIDTH-1:0] exp_w;
    apply_reset();
    out_ready = 1'b1;
    for (int l = 0; l < LANES; l++) tx_word[l] = 15'h7FFF - 15'(l);
    send_frames(8'hFF);
    tick();
    for (int l = 0; l < LANES; l++) begin
      tick();
      exp_w = 15'h7FFF - 15'(l);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL all_valid[%0d] got=%b exp=1", l, out_valid); end
      total++; if (out_lane !== 3'(l)) begin bad++; $display("FAIL all_lane[%0d] got=%0d exp=%0d", l, out_lane, l); end
      total++; if (out_data !== exp_w) begin bad++; $display("FAIL all_data[%0d] got=%h exp=%h", l, out_data, exp_w); end
    end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL all_drop got=%b exp=0", out_valid); end
    total++; if (overrun !== 8'h00) begin bad++; $display("FAIL all_overrun got=%h exp=00", overrun); end
  endtask

  task automatic test_stop_error();
    apply_reset();
    out_ready = 1'b1;
    tx_word[3] = 15'h0055;
    tx_stop[3] = 1'b1;
    send_frames(8'h08);
    tick();
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stop_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 15'h0055) begin bad++; $display("FAIL stop_data got=%h exp=0055", out_data); end
    total++; if (out_lane !== 3'd3) begin bad++; $display("FAIL stop_lane got=%0d exp=3", out_lane); end
    total++; if (out_err !== 1'b1) begin bad++; $display("FAIL stop_err got=%b exp=1", out_err); end
  endtask

  task automatic test_back_to_back_overrun();
    apply_reset();
    out_ready = 1'b0;
    // Park a lane-0 word in the output stage so lane 5's first word stays pending.
    tx_word[0] = 15'h0100;
    send_frames(8'h01);
    tick();
    tick();
    tx_word[5] = 15'h0001;
    send_frames(8'h20);
    tx_word[5] = 15'h0002;
    send_frames(8'h20);
    tick();
    total++; if (overrun !== 8'h20) begin bad++; $display("FAIL ovr_flag got=%h exp=20", overrun); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ovr_hold_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 15'h0100) begin bad++; $display("FAIL ovr_hold_data got=%h exp=0100", out_data); end
    total++; if (out_lane !== 3'd0) begin bad++; $display("FAIL ovr_hold_lane got=%0d exp=0", out_lane); end
    out_ready = 1'b1;
    tick();
    total++; if (out_data !== 15'h0002) begin bad++; $display("FAIL ovr_new_data got=%h exp=0002", out_data); end
    total++; if (out_lane !== 3'd5) begin bad++; $display("FAIL ovr_new_lane got=%0d exp=5", out_lane); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovr_drop got=%b exp=0", out_valid); end
    total++; if (overrun !== 8'h20) begin bad++; $display("FAIL ovr_sticky got=%h exp=20", overrun); end
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    total++; if (overrun !== 8'h00) begin bad++; $display("FAIL ovr_clear got=%h exp=00", overrun); end
  endtask

  task automatic test_reset_mid_frame();
    int seen;
    apply_reset();
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(posedge CLK);
      #1;
      ser_in[2] = (t == 0) || (t % 2 == 1);
    end
    RST_N = 1'b0;
    ser_in = '0;
    @(posedge CLK);
    #1;
    total++; if (lane_state !== 16'h0) begin bad++; $display("FAIL mid_state got=%h exp=0000", lane_state); end
    RST_N = 1'b1;
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL mid_no_output got=%0d exp=0", seen); end
    tx_word[2] = 15'h2AAA;
    send_frames(8'h04);
    tick();
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 15'h2AAA) begin bad++; $display("FAIL mid_data got=%h exp=2aaa", out_data); end
    total++; if (out_lane !== 3'd2) begin bad++; $display("FAIL mid_lane got=%0d exp=2", out_lane); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL mid_err got=%b exp=0", out_err); end
  endtask

`ifdef READOUT_RX_PARITY_EN
  task automatic test_parity();
    apply_reset();
    out_ready = 1'b1;
    tx_word[0] = 15'h0003;
    tx_flip[0] = 1'b1;
    send_frames(8'h01);
    tick();
    tick();
    total++; if (out_data !== 15'h0003) begin bad++; $display("FAIL par_bad_data got=%h exp=0003", out_data); end
    total++; if (out_err !== 1'b1) begin bad++; $display("FAIL par_bad_err got=%b exp=1", out_err); end
    tx_flip[0] = 1'b0;
    send_frames(8'h01);
    tick();
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL par_ok_valid got=%b exp=1", out_valid); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL par_ok_err got=%b exp=0", out_err); end
  endtask
`endif

  // report
  initial begin
    test_reset();
    test_single_frame();
    test_all_lanes();
    test_stop_error();
    test_back_to_back_overrun();
    test_reset_mid_frame();
`ifdef READOUT_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
